// File: rtl/bus_reg_responder.sv
// ---------------------------------------------------------------------------
// bus_reg_responder
//
// Purpose:
//   Target end of the memory write and read buses. Two write initiators share
//   one write port through a round-robin arbiter. A single read port returns
//   data through a one-deep registered response stage. The storage is a
//   flop-based register file of RAM_DEPTH words. Accesses at or above
//   RAM_DEPTH are still handshaken. They never touch storage, read back as
//   zero, and raise a sticky error flag.
//
// Parameters:
//   DATA_W    register and bus data width
//   ADDR_W    bus address width
//   RAM_DEPTH number of implemented registers (must be <= 2**ADDR_W)
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   w0_valid/ready/addr/data  write initiator 0 (valid/ready handshake)
//   w1_valid/ready/addr/data  write initiator 1 (valid/ready handshake)
//   r_valid/r_ready/r_addr    read request channel
//   rsp_valid/rsp_ready/rsp_data  read response channel (registered)
//   addr_err             sticky out-of-range access flag
// ---------------------------------------------------------------------------
module bus_reg_responder #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int RAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w0_valid,
  output logic              w0_ready,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  input  logic              w1_valid,
  output logic              w1_ready,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              addr_err
);

  // Index width for the register file. At least one bit, so that a
  // single-entry bank still has a legal select.
  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  // Depth held one bit wider than the address. The compare then stays
  // meaningful when RAM_DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(RAM_DEPTH);

  // Returns true when the address maps onto an implemented register.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [RAM_DEPTH];
  logic [DATA_W-1:0] regs_d [RAM_DEPTH];

  // Round-robin pointer: 0 = initiator 0 wins a tie, 1 = initiator 1 wins.
  logic              prio_q;
  logic              prio_d;

  logic              rsp_valid_q;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q;
  logic [DATA_W-1:0] rsp_data_d;
  logic              addr_err_q;
  logic              addr_err_d;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic              gnt0_s;
  logic              gnt1_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              wr_in_range_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic              rd_acc_s;
  logic              rd_in_range_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              r_ready_s;

  // Write arbiter. A lone requester always wins. On a tie the pointer picks
  // the initiator that was not granted last.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (w0_valid && w1_valid) begin
      if (prio_q == 1'b0) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else if (w0_valid) begin
      gnt0_s = 1'b1;
    end else if (w1_valid) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Pointer update. After a grant, priority passes to the other initiator.
  always_comb begin
    prio_d = prio_q;
    if (gnt0_s) begin
      prio_d = 1'b1;
    end else if (gnt1_s) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  // Mux the granted initiator onto the single write port.
  always_comb begin
    wr_en_s   = gnt0_s | gnt1_s;
    wr_addr_s = w0_addr;
    wr_data_s = w0_data;
    if (gnt1_s) begin
      wr_addr_s = w1_addr;
      wr_data_s = w1_data;
    end else begin
      wr_addr_s = w0_addr;
      wr_data_s = w0_data;
    end
    wr_in_range_s = addr_in_range(wr_addr_s);
    wr_idx_s      = wr_addr_s[IDX_W-1:0];
  end

  // Register-file next state. Out-of-range writes are acknowledged but dropped.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_s && wr_in_range_s) begin
      regs_d[wr_idx_s] = wr_data_s;
    end else begin
      regs_d = regs_q;
    end
  end

  // Read acceptance. The response stage can take a new request when it is
  // empty, or when its current word leaves on this same edge.
  always_comb begin
    r_ready_s     = (~rsp_valid_q) | rsp_ready;
    rd_acc_s      = r_valid & r_ready_s;
    rd_in_range_s = addr_in_range(r_addr);
    rd_idx_s      = r_addr[IDX_W-1:0];
  end

  // Response stage next state. The read samples regs_q, not regs_d, so a
  // same-cycle write to the same address is seen only by later reads.
  // rsp_data changes only on an accepted request. It never follows
  // rsp_ready combinationally.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (rd_acc_s) begin
      rsp_valid_d = 1'b1;
      if (rd_in_range_s) begin
        rsp_data_d = regs_q[rd_idx_s];
      end else begin
        rsp_data_d = {DATA_W{1'b0}};
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Sticky error. Set by any handshaken access that falls outside the bank.
  always_comb begin
    addr_err_d = addr_err_q;
    if ((wr_en_s && !wr_in_range_s) || (rd_acc_s && !rd_in_range_s)) begin
      addr_err_d = 1'b1;
    end else begin
      addr_err_d = addr_err_q;
    end
  end

  // State registers. Reset drops any pending response and any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q      <= '{default: '0};
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DATA_W{1'b0}};
      addr_err_q  <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign w0_ready  = gnt0_s;
  assign w1_ready  = gnt1_s;
  assign r_ready   = r_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_bus_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_reg_responder
//
// Directed bench for bus_reg_responder, built with RAM_DEPTH = 128 so that
// the out-of-range path can be exercised. Inputs change 1 ns after each
// rising edge. A reference model samples everything on the falling edge.
// The model keeps the register contents in a plain array, the outstanding
// response as a value/flag pair, and the last winner of a write grant.
// ---------------------------------------------------------------------------
module tb_bus_reg_responder;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 128;

  logic          clk;
  logic          rst;
  logic          w0_valid, w0_ready;
  logic [AW-1:0] w0_addr;
  logic [DW-1:0] w0_data;
  logic          w1_valid, w1_ready;
  logic [AW-1:0] w1_addr;
  logic [DW-1:0] w1_data;
  logic          r_valid, r_ready;
  logic [AW-1:0] r_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  bus_reg_responder #(.DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .addr_err(addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  logic [DW-1:0] mem_m [256];
  logic          rv_m;
  logic [DW-1:0] rd_m;
  logic          err_m;
  logic          last_w1_m;   // 1: initiator 1 won the last grant
  logic          e_g0, e_g1, e_rr;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        rv_m = 1'b0; rd_m = '0; err_m = 1'b0; last_w1_m = 1'b1;
      end
      e_g0 = w0_valid;
      e_g1 = w1_valid;
      if (w0_valid && w1_valid) begin
        e_g0 = last_w1_m;
        e_g1 = !last_w1_m;
      end
      e_rr = !rv_m || rsp_ready;
      check("cyc w0_ready", {31'd0, w0_ready}, {31'd0, e_g0});
      check("cyc w1_ready", {31'd0, w1_ready}, {31'd0, e_g1});
      check("cyc r_ready", {31'd0, r_ready}, {31'd0, e_rr});
      check("cyc rsp_valid", {31'd0, rsp_valid}, {31'd0, rv_m});
      check("cyc rsp_data", rsp_data, rd_m);
      check("cyc addr_err", {31'd0, addr_err}, {31'd0, err_m});
      if (!rst) begin
        // A read sees memory before this edge's write.
        if (r_valid && e_rr) begin
          rv_m = 1'b1;
          rd_m = (int'(r_addr) < DEPTH) ? mem_m[r_addr] : '0;
          if (int'(r_addr) >= DEPTH) err_m = 1'b1;
        end else if (rsp_ready) begin
          rv_m = 1'b0;
        end
        if (e_g0) begin
          if (int'(w0_addr) < DEPTH) mem_m[w0_addr] = w0_data; else err_m = 1'b1;
          last_w1_m = 1'b0;
        end
        if (e_g1) begin
          if (int'(w1_addr) < DEPTH) mem_m[w1_addr] = w1_data; else err_m = 1'b1;
          last_w1_m = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input int sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    logic rdy;
    n = 0;
    if (sel == 0) begin w0_valid = 1'b1; w0_addr = a; w0_data = d; end
    else          begin w1_valid = 1'b1; w1_addr = a; w1_data = d; end
    #1;
    rdy = (sel == 0) ? w0_ready : w1_ready;
    while (!rdy && n < 20) begin
      step();
      n++;
      rdy = (sel == 0) ? w0_ready : w1_ready;
    end
    check("write handshake", {31'd0, rdy}, 32'd1);
    step();
    w0_valid = 1'b0;
    w1_valid = 1'b0;
  endtask

  task automatic read_one(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    int n;
    n = 0;
    r_valid = 1'b1;
    r_addr  = a;
    #1;
    while (!r_ready && n < 20) begin
      step();
      n++;
    end
    check({nm, " r_ready"}, {31'd0, r_ready}, 32'd1);
    step();
    r_valid = 1'b0;
    check({nm, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({nm, " rsp_data"}, rsp_data, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, i0, i1;
    logic g0, g1;
    rst = 1'b1;
    w0_valid = 1'b0; w0_addr = '0; w0_data = '0;
    w1_valid = 1'b0; w1_addr = '0; w1_data = '0;
    r_valid = 1'b0; r_addr = '0; rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset addr_err", {31'd0, addr_err}, 32'd0);

    // 1: read from a freshly reset register
    read_one(8'h05, 32'h0000_0000, "t1 read 05");
    check("t1 addr_err", {31'd0, addr_err}, 32'd0);

    // 2: simple write then read back
    write_one(0, 8'h10, 32'h0000_0003);
    read_one(8'h10, 32'h0000_0003, "t2 read 10");

    // Initiator 1 goes last here, so initiator 0 wins the first tie below.
    write_one(1, 8'h50, 32'h0000_0001);

    // 3: both initiators streaming, grants must alternate w0,w1,...
    i0 = 0; i1 = 0; k = 0;
    while ((i0 < 4 || i1 < 4) && k < 40) begin
      w0_valid = (i0 < 4); w0_addr = 8'h20 + 8'(i0); w0_data = 32'h0000_2000 + 32'(i0);
      w1_valid = (i1 < 4); w1_addr = 8'h30 + 8'(i1); w1_data = 32'h0000_3000 + 32'(i1);
      #1;
      g0 = w0_ready;
      g1 = w1_ready;
      if (k < 8) begin
        check("t3 grant w0", {31'd0, g0}, (k % 2 == 0) ? 32'd1 : 32'd0);
        check("t3 grant w1", {31'd0, g1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      end
      step();
      if (g0) i0++;
      if (g1) i1++;
      k++;
    end
    w0_valid = 1'b0; w1_valid = 1'b0;
    check("t3 grant cycles", 32'(k), 32'd8);
    for (int i = 0; i < 4; i++) begin
      read_one(8'h20 + 8'(i), 32'h0000_2000 + 32'(i), "t3 read w0");
      read_one(8'h30 + 8'(i), 32'h0000_3000 + 32'(i), "t3 read w1");
    end

    // 4: stalled response, then back-to-back reads
    write_one(0, 8'h40, 32'hDEAD_BEEF);
    write_one(0, 8'h41, 32'h1234_5678);
    rsp_ready = 1'b0; r_valid = 1'b1; r_addr = 8'h40;
    step();
    r_addr = 8'h41;
    for (int i = 0; i < 5; i++) begin
      check("t4 stall r_ready", {31'd0, r_ready}, 32'd0);
      check("t4 stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("t4 stall rsp_data", rsp_data, 32'hDEAD_BEEF);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("t4 release r_ready", {31'd0, r_ready}, 32'd1);
    step();
    check("t4 b2b data 41", rsp_data, 32'h1234_5678);
    r_addr = 8'h40;
    step();
    check("t4 b2b data 40", rsp_data, 32'hDEAD_BEEF);
    check("t4 b2b valid", {31'd0, rsp_valid}, 32'd1);
    r_valid = 1'b0;
    step();
    check("t4 drain valid", {31'd0, rsp_valid}, 32'd0);
    check("t4 drain data hold", rsp_data, 32'hDEAD_BEEF);

    // 5: same-cycle write and read of one address returns the old value
    w0_valid = 1'b1; w0_addr = 8'h50; w0_data = 32'hAAAA_5555;
    r_valid = 1'b1; r_addr = 8'h50;
    #1;
    check("t5 w0_ready", {31'd0, w0_ready}, 32'd1);
    step();
    w0_valid = 1'b0; r_valid = 1'b0;
    check("t5 read-first data", rsp_data, 32'h0000_0001);
    read_one(8'h50, 32'hAAAA_5555, "t5 read after write");

    // 6: out-of-range accesses, sticky error, reset during a stall
    write_one(0, 8'h80, 32'h0000_1234);
    check("t6 err after write", {31'd0, addr_err}, 32'd1);
    read_one(8'h80, 32'h0000_0000, "t6 read 80");
    repeat (100) step();
    check("t6 err sticky", {31'd0, addr_err}, 32'd1);
    rsp_ready = 1'b0; r_valid = 1'b1; r_addr = 8'h10;
    step();
    r_valid = 1'b0;
    check("t6 stalled valid", {31'd0, rsp_valid}, 32'd1);
    check("t6 stalled data", rsp_data, 32'h0000_0003);
    rst = 1'b1;
    #1;
    check("t6 rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t6 rst rsp_data", rsp_data, 32'd0);
    check("t6 rst addr_err", {31'd0, addr_err}, 32'd0);
    step();
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    read_one(8'h10, 32'h0000_0000, "t6 cleared 10");
    read_one(8'h50, 32'h0000_0000, "t6 cleared 50");
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_reg_responder.md
Name: bus_reg_responder

Overview:
- Responder (target) end of the memory write and read buses.
- Accepts address/data writes from two initiators, for example the periodic button writer and a motor-control block.
- Stores them in a flop-based register file and serves read requests with a registered response handshake.
- Used as the local register bank behind the bus interfaces, in place of the UART-synchronised memory, in designs that need no host link.

Parameters:
- DATA_W, 32, register and bus data width.
- ADDR_W, 8, bus address width.
- RAM_DEPTH, 256, number of implemented registers; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- w0_valid  in  1  initiator 0 write request
- w0_ready  out  1  initiator 0 write accepted this cycle
- w0_addr  in  ADDR_W  initiator 0 write address
- w0_data  in  DATA_W  initiator 0 write data
- w1_valid, w1_ready, w1_addr, w1_data: same as w0_*, for initiator 1
- r_valid  in  1  read request
- r_ready  out  1  read request accepted this cycle
- r_addr  in  ADDR_W  read address
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  read response consumed
- rsp_data  out  DATA_W  read response data
- addr_err  out  1  sticky flag: an access targeted an address ≥ RAM_DEPTH

Behaviour:
- Reset: already decided, one clock, reset is asynchronous and active-high (clk, rst). On rst:
  - all RAM_DEPTH registers clear to 0;
  - rsp_valid=0, rsp_data=0, addr_err=0;
  - round-robin pointer = initiator 0 has priority.
- Reset mid-transaction: a pending response is discarded and any write in flight is not committed.
- Write arbitration (combinational grant, registered pointer):
  - Only w0_valid high: w0_ready=1. Only w1_valid high: w1_ready=1.
  - Both high: the initiator not granted last is granted; the pointer flips after every grant.
  - At most one of w0_ready/w1_ready is high in any cycle; neither is high when its valid is low.
  - A handshake (valid & ready) commits data at that rising edge.
  - The losing initiator must hold valid, addr and data stable until its own ready.
  - Writes are never blocked by read activity.
- Out-of-range write (addr ≥ RAM_DEPTH): still handshaken, data dropped, addr_err set.
- Read request:
  - r_ready = !rsp_valid || rsp_ready, a one-deep response pipeline with full throughput.
  - On r_valid & r_ready, the next cycle has rsp_valid=1 and rsp_data = register value (latency 1).
  - Out-of-range read: rsp_data=0 and addr_err set.
- Response hold: while rsp_valid & !rsp_ready, rsp_data and rsp_valid hold and r_ready=0.
  - On rsp_ready with no new accepted request, rsp_valid goes to 0 next cycle. rsp_data keeps its last value.
- Read and write to the same address in the same cycle: read-first; the response carries the pre-write value. The write is visible to a request accepted one cycle later.
- addr_err clears only on rst.
- No other state; no combinational path from rsp_ready to rsp_data.

Test Plan:
1. Reset, then read addr 0x05 -> rsp_valid one cycle after accept, rsp_data=0, addr_err=0.
2. w0 writes 0x0000_0003 to 0x10, then read 0x10 -> rsp_data=0x0000_0003 one cycle after r_ready handshake.
3. w0 and w1 valid together for 4 consecutive requests each (w0: 0x20..0x23, w1: 0x30..0x33) -> grants alternate w0,w1,w0,… starting with w0; never both ready; all 8 values read back correctly.
4. Read 0x40 with rsp_ready=0 for 5 cycles, r_valid held -> rsp_data stable, r_ready=0 throughout. Release rsp_ready -> back-to-back responses, one per cycle.
5. Same-cycle write 0xAAAA_5555 and read to 0x50 (old value 0x1) -> rsp_data=0x1; the next read returns 0xAAAA_5555.
6. With RAM_DEPTH=128: write to 0x80, then read 0x80 -> write acknowledged, rsp_data=0, addr_err=1 and still set after 100 cycles. Assert rst during a stalled response -> rsp_valid=0 immediately, addr_err=0.
